uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the two-port UART TX arbiter.
// The arbiter uses the slave view; the surrounding system (requesters + UART) uses the master view.
interface uart_tx_arbiter_if;
   logic [1:0] req_valid;
   logic [7:0] req_data0;
   logic [7:0] req_data1;
   logic [1:0] ack;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;

   modport master (
      output req_valid,
      output req_data0,
      output req_data1,
      output tx_busy,
      input  ack,
      input  tx_data,
      input  tx_start
   );

   modport slave (
      input  req_valid,
      input  req_data0,
      input  req_data1,
      input  tx_busy,
      output ack,
      output tx_data,
      output tx_start
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte requesters,
// with a start timeout and an enforced idle gap between frames.
module uart_tx_arbiter #(
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   uart_tx_arbiter_if.slave bus,
   output logic [1:0]       grant,
   output logic [7:0]       sent_count,
   output logic             err_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      SENDING,
      GAP
   } state_t;

   localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(START_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       last_q, last_d;
   logic [1:0] grant_q, grant_d;
   logic [7:0] data_q, data_d;
   logic       start_q, start_d;
   logic [1:0] ack_q, ack_d;
   logic [7:0] count_q, count_d;
   logic       err_q, err_d;
   logic       pick_one;

   // On a tie the requester that did not own the previous frame wins.
   assign pick_one = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];

   assign bus.tx_data  = data_q;
   assign bus.tx_start = start_q;
   assign bus.ack      = ack_q;
   assign grant        = grant_q;
   assign sent_count   = count_q;
   assign err_timeout  = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
         data_q  <= 8'h00;
         start_q <= 1'b0;
         ack_q   <= 2'b00;
         count_q <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         start_q <= start_d;
         ack_q   <= ack_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // The launch pulse and ack are registered out of LAUNCH, so they appear
   // the cycle after the grant decision; cnt is shared by WAIT_BUSY and GAP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      grant_d = grant_q;
      data_d  = data_q;
      start_d = 1'b0;
      ack_d   = 2'b00;
      count_d = count_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (en && (bus.req_valid != 2'b00)) begin
               grant_d = pick_one ? 2'b10 : 2'b01;
               data_d  = pick_one ? bus.req_data1 : bus.req_data0;
               last_d  = pick_one;
               state_d = LAUNCH;
            end else begin
               grant_d = 2'b00;
            end
         end

         LAUNCH: begin
            start_d = 1'b1;
            ack_d   = grant_q;
            cnt_d   = 8'd0;
            state_d = WAIT_BUSY;
         end

         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = SENDING;
            end else if (cnt_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               grant_d = 2'b00;
               cnt_d   = 8'd0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         SENDING: begin
            if (!bus.tx_busy) begin
               count_d = count_q + 8'd1;
               grant_d = 2'b00;
               cnt_d   = 8'd0;
               state_d = GAP;
            end
         end

         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 8'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of single-frame vectors plus
// hand-written sequences for en gating, start timeout, mid-frame reset and counter wrap.
module tb_uart_tx_arbiter;

   localparam int GAP_N    = 6;
   localparam int TMO_N    = 5;
   localparam int BUSY_LEN = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] grant;
   logic [7:0] sent_count;
   logic       err_timeout;

   int n_vec  = 0;
   int n_miss = 0;
   int busy_left = 0;
   bit model_on  = 1'b1;
   bit auto_drop = 1'b1;

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter #(
      .GAP_CYCLES   (GAP_N),
      .START_TIMEOUT(TMO_N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .bus        (bus.slave),
      .grant      (grant),
      .sent_count (sent_count),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] exp_grant;
      logic [7:0] exp_data;
      logic [7:0] exp_count;
   } vec_t;

   vec_t vecs[9];

   task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   // One clock step; the UART model and requester ack-drop react just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (model_on) begin
         if (bus.tx_start) busy_left = BUSY_LEN;
         bus.tx_busy = (busy_left != 0);
         if (busy_left != 0) busy_left--;
      end else begin
         bus.tx_busy = 1'b0;
      end
      if (auto_drop) bus.req_valid = bus.req_valid & ~bus.ack;
   endtask

   task automatic wait_start(input string name, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (bus.tx_start) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_miss++;
         $display("[TB] FAIL %s: tx_start got 0, expected 1 within 60 cycles", name);
      end
   endtask

   task automatic wait_grant_clear(input string name);
      bit done;
      done = (grant == 2'b00);
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         if (grant == 2'b00) done = 1'b1;
      end
      if (!done) begin
         n_vec++;
         n_miss++;
         $display("[TB] FAIL %s: grant got %b, expected 00 within 60 cycles", name, grant);
      end
   endtask

   task automatic do_reset(input string name);
      @(posedge clk);
      #1;
      rst = 1'b0;
      busy_left   = 0;
      bus.tx_busy = 1'b0;
      #2;
      check_output({name, " grant"},    8'(grant),        8'h00);
      check_output({name, " ack"},      8'(bus.ack),      8'h00);
      check_output({name, " tx_start"}, 8'(bus.tx_start), 8'h00);
      check_output({name, " tx_data"},  bus.tx_data,      8'h00);
      check_output({name, " count"},    sent_count,       8'h00);
      check_output({name, " err"},      8'(err_timeout),  8'h00);
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      bit seen;
      bus.req_valid = v.req;
      bus.req_data0 = v.d0;
      bus.req_data1 = v.d1;
      wait_start($sformatf("v%0d start", idx), seen);
      if (seen) begin
         check_output($sformatf("v%0d ack", idx),     8'(bus.ack), 8'(v.exp_grant));
         check_output($sformatf("v%0d grant", idx),   8'(grant),   8'(v.exp_grant));
         check_output($sformatf("v%0d tx_data", idx), bus.tx_data, v.exp_data);
         tick();
         check_output($sformatf("v%0d start_pulse", idx), 8'(bus.tx_start), 8'h00);
         check_output($sformatf("v%0d ack_pulse", idx),   8'(bus.ack),      8'h00);
         wait_grant_clear($sformatf("v%0d end", idx));
         check_output($sformatf("v%0d count", idx),     sent_count,  v.exp_count);
         check_output($sformatf("v%0d data_hold", idx), bus.tx_data, v.exp_data);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit seen;
      int starts;
      logic [1:0] exp_alt;

      vecs[0] = '{2'b11, 8'h3A, 8'h5C, 2'b01, 8'h3A, 8'd1};
      vecs[1] = '{2'b10, 8'h3A, 8'h5C, 2'b10, 8'h5C, 8'd2};
      vecs[2] = '{2'b11, 8'hA1, 8'hB2, 2'b01, 8'hA1, 8'd3};
      vecs[3] = '{2'b11, 8'hC3, 8'hD4, 2'b10, 8'hD4, 8'd4};
      vecs[4] = '{2'b01, 8'h11, 8'h22, 2'b01, 8'h11, 8'd5};
      vecs[5] = '{2'b01, 8'h33, 8'h44, 2'b01, 8'h33, 8'd6};
      vecs[6] = '{2'b11, 8'h55, 8'h66, 2'b10, 8'h66, 8'd7};
      vecs[7] = '{2'b10, 8'h77, 8'h88, 2'b10, 8'h88, 8'd8};
      vecs[8] = '{2'b11, 8'h99, 8'hAA, 2'b01, 8'h99, 8'd9};

      rst           = 1'b1;
      en            = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_data0 = 8'h00;
      bus.req_data1 = 8'h00;
      bus.tx_busy   = 1'b0;

      do_reset("reset0");
      for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], i);

      // Both requesters held continuously: ownership must alternate.
      do_reset("reset1");
      auto_drop     = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_data0 = 8'h10;
      bus.req_data1 = 8'h20;
      exp_alt       = 2'b01;
      for (int i = 0; i < 4; i++) begin
         wait_start($sformatf("alt%0d start", i), seen);
         check_output($sformatf("alt%0d grant", i), 8'(grant), 8'(exp_alt));
         wait_grant_clear($sformatf("alt%0d end", i));
         exp_alt = ~exp_alt;
      end
      bus.req_valid = 2'b00;
      auto_drop     = 1'b1;
      check_output("alt count", sent_count, 8'd4);

      // en low blocks grants; raising it launches two cycles later.
      en            = 1'b0;
      bus.req_valid = 2'b01;
      bus.req_data0 = 8'h5A;
      starts = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.tx_start) starts++;
      end
      check_output("en0 no_start", 8'(starts), 8'h00);
      check_output("en0 grant", 8'(grant), 8'h00);
      en = 1'b1;
      tick();
      check_output("en1 start_c1", 8'(bus.tx_start), 8'h00);
      tick();
      check_output("en1 start_c2", 8'(bus.tx_start), 8'h01);
      check_output("en1 tx_data", bus.tx_data, 8'h5A);
      en = 1'b0;
      wait_grant_clear("en_drop end");
      check_output("en_drop count", sent_count, 8'd5);
      bus.req_valid = 2'b10;
      starts = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.tx_start) starts++;
      end
      check_output("en0 pending", 8'(starts), 8'h00);
      bus.req_valid = 2'b00;
      en = 1'b1;

      // Transmitter never goes busy: timeout, sticky error, then gap back to IDLE.
      do_reset("reset2");
      model_on      = 1'b0;
      bus.req_valid = 2'b01;
      bus.req_data0 = 8'h77;
      wait_start("tmo start", seen);
      for (int i = 0; i < TMO_N - 1; i++) tick();
      check_output("tmo err_early", 8'(err_timeout), 8'h00);
      tick();
      check_output("tmo err", 8'(err_timeout), 8'h01);
      check_output("tmo grant", 8'(grant), 8'h00);
      check_output("tmo count", sent_count, 8'h00);
      bus.req_valid = 2'b10;
      bus.req_data1 = 8'h88;
      for (int i = 0; i < GAP_N + 1; i++) tick();
      check_output("tmo gap_start0", 8'(bus.tx_start), 8'h00);
      tick();
      check_output("tmo gap_start1", 8'(bus.tx_start), 8'h01);
      check_output("tmo gap_data", bus.tx_data, 8'h88);
      wait_grant_clear("tmo2 end");
      check_output("tmo sticky", 8'(err_timeout), 8'h01);
      check_output("tmo count2", sent_count, 8'h00);
      model_on = 1'b1;

      // Reset while SENDING abandons the frame; requester 0 wins the re-grant tie.
      bus.req_valid = 2'b11;
      bus.req_data0 = 8'h21;
      bus.req_data1 = 8'h43;
      wait_start("rst_mid start", seen);
      tick();
      tick();
      bus.req_valid = 2'b11;
      do_reset("rst_mid");
      wait_start("rst_mid regrant", seen);
      check_output("rst_mid grant", 8'(grant), 8'h01);
      check_output("rst_mid ack", 8'(bus.ack), 8'h01);
      check_output("rst_mid tx_data", bus.tx_data, 8'h21);
      check_output("rst_mid count0", sent_count, 8'h00);
      wait_grant_clear("rst_mid end");
      check_output("rst_mid count1", sent_count, 8'h01);

      // Drive the frame counter up to 255 and across the wrap.
      for (int i = 0; i < 254; i++) begin
         bus.req_valid = 2'b01;
         wait_start("wrap start", seen);
         wait_grant_clear("wrap end");
      end
      check_output("wrap count255", sent_count, 8'hFF);
      bus.req_valid = 2'b10;
      bus.req_data1 = 8'hE7;
      wait_start("wrap last", seen);
      wait_grant_clear("wrap last end");
      check_output("wrap count0", sent_count, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
